// File: rtl/report_collector_c6lw.sv
// report_collector_c6lw
// Collects the 40 stage-0 report wires of cluster 6 (10 LTL automata x 4
// reports). Every run cycle with at least one report active is timestamped
// and queued in a FIFO. The monitor drains the FIFO through a valid/ready
// handshake. Sticky per-automaton hit flags and drop statistics are also kept.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               symbol-advance enable (same as stage 0)
//   report_vec[39:0]  bit 4k+j = automaton k report j
//   clr_sticky        pulse: clears ltl_hit, overflow, drop_cnt
//   rd_valid/rd_ready readout handshake; rd_cycle/rd_reports = head entry
//   fifo_level        occupancy 0..DEPTH
//   overflow          sticky: an entry was dropped on a full FIFO
//   drop_cnt          saturating count of dropped entries
//   ltl_hit[9:0]      sticky: automaton k reported at least once
module report_collector_c6lw #(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [39:0]              report_vec,
    input  logic                     clr_sticky,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [CNT_W-1:0]         rd_cycle,
    output logic [39:0]              rd_reports,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [9:0]               ltl_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + 40;

    logic [CNT_W-1:0] cycle_cnt;
    logic             cap_vld;
    logic [EW-1:0]    cap_reg;     // {timestamp, report vector}
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [9:0]       hit_set;

    always_comb begin
        hit_set = '0;
        for (int k = 0; k < 10; k++)
            hit_set[k] = run & (|report_vec[4*k +: 4]);
    end

    assign pop   = (level != '0) & rd_ready;
    // Fullness is judged after the same-cycle pop, so a full FIFO being
    // drained still accepts the incoming entry.
    assign full  = (level == (AW+1)'(DEPTH)) & ~pop;
    assign wr_en = cap_vld & ~full;
    assign drop  = cap_vld & full;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            cap_vld   <= 1'b0;
            cap_reg   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            ltl_hit   <= '0;
        end else begin
            if (run)
                cycle_cnt <= cycle_cnt + CNT_W'(1);

            // Timestamp is the pre-increment count of this run cycle.
            cap_vld <= run & (report_vec != '0);
            cap_reg <= {cycle_cnt, report_vec};

            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);

            case ({wr_en, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase

            // A set event in the same cycle as clr_sticky wins.
            ltl_hit <= clr_sticky ? hit_set : (ltl_hit | hit_set);

            if (drop) begin
                overflow <= 1'b1;
                if (clr_sticky)
                    drop_cnt <= DROP_W'(1);
                else if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_W'(1);
            end else if (clr_sticky) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Storage needs no reset; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[wr_ptr] <= cap_reg;
    end

    assign rd_valid   = (level != '0);
    assign fifo_level = level;
    assign rd_cycle   = rd_valid ? mem[rd_ptr][EW-1:40] : '0;
    assign rd_reports = rd_valid ? mem[rd_ptr][39:0]    : '0;

endmodule
